// File: rtl/forth_pool.sv
// forth_pool: byte-wide ForthSuper dictionary pool with single-byte R1/W1 and a multi-cycle FIND.
// Define POOL_FIND_EN to compile in FIND and its MATCH/SKIP/DONE states; without it FIND is a NOP.

typedef enum logic [2:0] {NOP = 3'd0, R1 = 3'd1, W1 = 3'd2, FIND = 3'd3} pool_op_t;

module forth_pool #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     op,
  input  logic [ASZ-1:0] ai,
  input  logic [DSZ-1:0] vi,
  output logic           we,
  output logic [DSZ-1:0] vo,
  output logic [1:0]     st,
  output logic           bsy,
  output logic [ASZ-1:0] ao,
  output logic [ASZ-1:0] ao1
);

  typedef enum logic [1:0] {IDLE = 2'd0, MATCH = 2'd1, SKIP = 2'd2, DONE = 2'd3} state_t;

  localparam int DEPTH = 1 << ASZ;

  logic [DSZ-1:0] mem [DEPTH];

  state_t         state, state_nx;
  logic [ASZ-1:0] key, key_nx, start, start_nx, ao_nx, ao1_nx;
  logic [DSZ-1:0] vo_nx;
  logic           accept;

  assign accept = (state == IDLE) || (state == DONE);
  assign st     = state;
  assign bsy    = (state == MATCH) || (state == SKIP);

  // Storage is deliberately left out of reset so the dictionary survives an abort.
  always_ff @(posedge clk) begin
    if (!rst && accept && op == W1) begin
      mem[ai] <= vi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ao    <= '0;
      ao1   <= '0;
      key   <= '0;
      start <= '0;
      vo    <= '0;
      we    <= 1'b0;
    end else begin
      state <= state_nx;
      ao    <= ao_nx;
      ao1   <= ao1_nx;
      key   <= key_nx;
      start <= start_nx;
      vo    <= vo_nx;
      we    <= accept && (op == W1);
    end
  end

`ifdef POOL_FIND_EN
  logic [DSZ-1:0] c, k;
  assign c = mem[ao];
  assign k = mem[ao1];
`endif

  // Leaving MATCH/SKIP loads the result address and flag, so DONE shows them for one cycle.
  always_comb begin
    state_nx = state;
    ao_nx    = ao;
    ao1_nx   = ao1;
    key_nx   = key;
    start_nx = start;
    vo_nx    = vo;
    case (state)
`ifdef POOL_FIND_EN
      MATCH: begin
        if (ao >= key) begin
          state_nx = DONE;
          ao_nx    = key;
          vo_nx    = '0;
        end else if (c == k && c == '0) begin
          state_nx = DONE;
          ao_nx    = start;
          vo_nx    = DSZ'(1);
        end else if (c == k) begin
          ao_nx  = ao + ASZ'(1);
          ao1_nx = ao1 + ASZ'(1);
        end else if (c == '0) begin
          ao_nx    = ao + ASZ'(1);
          start_nx = ao + ASZ'(1);
          ao1_nx   = key;
        end else begin
          ao_nx    = ao + ASZ'(1);
          state_nx = SKIP;
        end
      end
      SKIP: begin
        if (ao >= key) begin
          state_nx = DONE;
          ao_nx    = key;
          vo_nx    = '0;
        end else if (c == '0) begin
          ao_nx    = ao + ASZ'(1);
          start_nx = ao + ASZ'(1);
          ao1_nx   = key;
          state_nx = MATCH;
        end else begin
          ao_nx = ao + ASZ'(1);
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        if (op == R1) begin
          vo_nx = mem[ai];
        end
`ifdef POOL_FIND_EN
        else if (op == FIND) begin
          key_nx   = ai;
          ao_nx    = '0;
          start_nx = '0;
          ao1_nx   = ai;
          state_nx = MATCH;
        end
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_forth_pool.sv
// Directed self-checking bench for forth_pool; FIND scenarios are exercised when POOL_FIND_EN is defined.

module tb_forth_pool;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [16:0] ai;
  logic [7:0]  vi;
  logic        we;
  logic [7:0]  vo;
  logic [1:0]  st;
  logic        bsy;
  logic [16:0] ao;
  logic [16:0] ao1;

  int passes = 0;
  int total  = 0;
  int busyCycles;

  logic [7:0] bigPool   [22];
  logic [7:0] smallPool [10];

  forth_pool #(.ASZ(17), .DSZ(8)) dut (
    .clk (clk),
    .rst (rst),
    .op  (op),
    .ai  (ai),
    .vi  (vi),
    .we  (we),
    .vo  (vo),
    .st  (st),
    .bsy (bsy),
    .ao  (ao),
    .ao1 (ao1)
  );

  always #5 clk = ~clk;

  // Drive one command across a rising edge; returns on the following falling edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [16:0] a, input logic [7:0] v);
    op = o;
    ai = a;
    vi = v;
    @(negedge clk);
    op = 3'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic waitDone(output int cycles);
    int guard;
    cycles = 0;
    guard  = 0;
    while (st != 2'd3 && guard < 200) begin
      if (bsy) cycles++;
      @(negedge clk);
      guard++;
    end
    checkOutput("done_reached", 32'(st), 32'd3);
  endtask

  initial begin
    rst = 1'b1;
    op  = 3'd0;
    ai  = '0;
    vi  = '0;
    for (int i = 0; i < 16; i++) bigPool[i] = 8'h61 + 8'(i);
    bigPool[16] = 8'h00;
    for (int i = 0; i < 4; i++) bigPool[17 + i] = 8'h61 + 8'(i);
    bigPool[21] = 8'h00;
    smallPool = '{8'h61, 8'h62, 8'h00, 8'h61, 8'h62, 8'h63, 8'h00, 8'h61, 8'h62, 8'h00};

    repeat (2) @(negedge clk);
    checkOutput("rst_st",  32'(st),  32'd0);
    checkOutput("rst_bsy", 32'(bsy), 32'd0);
    checkOutput("rst_we",  32'(we),  32'd0);
    checkOutput("rst_vo",  32'(vo),  32'd0);
    checkOutput("rst_ao",  32'(ao),  32'd0);
    checkOutput("rst_ao1", 32'(ao1), 32'd0);
    rst = 1'b0;

    $display("[TB] loading large pool");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(3'd2, 17'(i), bigPool[i]);
      checkOutput("we_pulse", 32'(we), 32'd1);
    end
    applyStimulus(3'd0, '0, '0);
    checkOutput("we_idle", 32'(we), 32'd0);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(3'd1, 17'(i), '0);
      checkOutput("r1_big", 32'(vo), 32'(bigPool[i]));
    end
    checkOutput("we_after_r1", 32'(we), 32'd0);
    applyStimulus(3'd5, 17'd3, 8'hff);
    checkOutput("op5_nop_vo", 32'(vo), 32'(bigPool[21]));
    checkOutput("op5_nop_we", 32'(we), 32'd0);

`ifdef POOL_FIND_EN
    $display("[TB] FIND of abcd in large pool");
    applyStimulus(3'd3, 17'h11, '0);
    waitDone(busyCycles);
    checkOutput("find_big_ao",   32'(ao), 32'h11);
    checkOutput("find_big_vo",   32'(vo), 32'd0);
    checkOutput("find_big_busy", 32'(busyCycles), 32'd18);
    applyStimulus(3'd0, '0, '0);
    checkOutput("after_done_st", 32'(st), 32'd0);

    $display("[TB] reset during FIND");
    applyStimulus(3'd3, 17'h11, '0);
    repeat (2) @(negedge clk);
    checkOutput("abort_bsy_before", 32'(bsy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_st",  32'(st),  32'd0);
    checkOutput("abort_bsy", 32'(bsy), 32'd0);
    checkOutput("abort_ao",  32'(ao),  32'd0);
    applyStimulus(3'd1, 17'h05, '0);
    checkOutput("abort_r1", 32'(vo), 32'h66);
`else
    $display("[TB] FIND compiled out");
    applyStimulus(3'd1, 17'h03, '0);
    applyStimulus(3'd3, 17'h11, '0);
    checkOutput("nofind_st",  32'(st),  32'd0);
    checkOutput("nofind_bsy", 32'(bsy), 32'd0);
    checkOutput("nofind_ao",  32'(ao),  32'd0);
    checkOutput("nofind_ao1", 32'(ao1), 32'd0);
    checkOutput("nofind_vo",  32'(vo),  32'h64);
    applyStimulus(3'd0, '0, '0);
    checkOutput("nofind_bsy2", 32'(bsy), 32'd0);
`endif

    $display("[TB] loading small pool");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'd2, 17'(i), smallPool[i]);
      checkOutput("we_small", 32'(we), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'd1, 17'(i), '0);
      checkOutput("r1_small", 32'(vo), 32'(smallPool[i]));
    end
    applyStimulus(3'd1, 17'h0a, '0);
    checkOutput("r1_big_tail", 32'(vo), 32'(bigPool[10]));

`ifdef POOL_FIND_EN
    $display("[TB] FIND ab / abc / empty key");
    applyStimulus(3'd3, 17'd7, '0);
    waitDone(busyCycles);
    checkOutput("find_ab_ao",   32'(ao), 32'd0);
    checkOutput("find_ab_vo",   32'(vo), 32'd1);
    checkOutput("find_ab_busy", 32'(busyCycles), 32'd3);

    applyStimulus(3'd3, 17'd3, '0);
    waitDone(busyCycles);
    checkOutput("find_abc_ao",   32'(ao), 32'd3);
    checkOutput("find_abc_vo",   32'(vo), 32'd0);
    checkOutput("find_abc_busy", 32'(busyCycles), 32'd4);

    applyStimulus(3'd3, 17'd0, '0);
    waitDone(busyCycles);
    checkOutput("find_k0_ao",   32'(ao), 32'd0);
    checkOutput("find_k0_vo",   32'(vo), 32'd0);
    checkOutput("find_k0_busy", 32'(busyCycles), 32'd1);

    $display("[TB] commands while busy");
    applyStimulus(3'd1, 17'd5, '0);
    checkOutput("pre_busy_r1", 32'(vo), 32'h63);
    applyStimulus(3'd3, 17'd7, '0);
    checkOutput("busy_bsy", 32'(bsy), 32'd1);
    checkOutput("busy_ao",  32'(ao),  32'd0);
    checkOutput("busy_ao1", 32'(ao1), 32'd7);
    applyStimulus(3'd2, 17'd0, 8'h7a);
    checkOutput("busy_w1_st",  32'(st),  32'd1);
    checkOutput("busy_w1_vo",  32'(vo),  32'h63);
    checkOutput("busy_w1_ao1", 32'(ao1), 32'd8);
    checkOutput("busy_w1_we",  32'(we),  32'd0);
    applyStimulus(3'd1, 17'd1, '0);
    checkOutput("busy_r1_vo",  32'(vo),  32'h63);
    checkOutput("busy_r1_bsy", 32'(bsy), 32'd1);
    @(negedge clk);
    checkOutput("busy_done_st", 32'(st), 32'd3);
    checkOutput("busy_done_vo", 32'(vo), 32'd1);
    checkOutput("busy_done_ao", 32'(ao), 32'd0);
    applyStimulus(3'd1, 17'd0, '0);
    checkOutput("busy_mem_kept", 32'(vo), 32'h61);
    checkOutput("accept_in_done_st", 32'(st), 32'd0);
`endif

    $display("[TB] reset clears outputs, keeps memory");
    applyStimulus(3'd1, 17'd4, '0);
    checkOutput("pre_rst_vo", 32'(vo), 32'h62);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst2_vo", 32'(vo), 32'd0);
    checkOutput("rst2_we", 32'(we), 32'd0);
    applyStimulus(3'd1, 17'd4, '0);
    checkOutput("rst2_mem", 32'(vo), 32'h62);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
